// File: rtl/watch_btn_pkg.sv
// Shared types and default timing constants for the button press classifier.
// Optional feature macro: BTN_DOUBLE_CLICK_EN adds the WAIT_DBL state.
package watch_btn_pkg;

   localparam int LONG_MS_DEF   = 1000;
   localparam int REPEAT_MS_DEF = 200;
   localparam int DBL_MS_DEF    = 300;
   localparam int CNT_W_DEF     = 12;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
`ifdef BTN_DOUBLE_CLICK_EN
      ,
      WAIT_DBL  = 2'd3
`endif
   } btn_state_e;

   // A tick threshold must be reachable by a CNT_W-bit counter without wrapping.
   function automatic bit cnt_fits(input int value, input int width);
      return (value > 0) && (longint'(value) < (longint'(1) << width));
   endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Event and classification signals between the debouncer side and the classifier.
interface button_press_classifier_if;
   logic tick;
   logic pb_down;
   logic pb_up;
   logic short_press;
   logic long_press;
   logic repeat_pulse;
   logic held;
   logic double_press;

   modport master (
      output tick, pb_down, pb_up,
      input  short_press, long_press, repeat_pulse, held, double_press
   );

   modport slave (
      input  tick, pb_down, pb_up,
      output short_press, long_press, repeat_pulse, held, double_press
   );
endinterface

// File: rtl/btn_tick_timer.sv
// Tick counter with compare-and-clear; it clears on the threshold tick so it
// never holds the limit value and therefore never wraps.
module btn_tick_timer #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             hit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Compare one bit wider so cnt_q + 1 cannot overflow before the compare.
   assign hit_o = inc_i && (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, limit_i});

   // Next count: clear wins, then the threshold tick clears, else count ticks.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || hit_o) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release events into short, long, auto-repeat and
// (optionally) double presses. All outputs are registered.
// Optional feature macro: BTN_DOUBLE_CLICK_EN enables double-press detection.
module button_press_classifier
   import watch_btn_pkg::*;
#(
   parameter int LONG_MS   = LONG_MS_DEF,
   parameter int REPEAT_MS = REPEAT_MS_DEF,
   parameter int DBL_MS    = DBL_MS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   button_press_classifier_if.slave  bus
);

   if (!cnt_fits(LONG_MS, CNT_W) || !cnt_fits(REPEAT_MS, CNT_W) || !cnt_fits(DBL_MS, CNT_W)) begin : g_bad_cfg
      $error("button_press_classifier: timing parameter out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] LONG_L   = CNT_W'(LONG_MS);
   localparam logic [CNT_W-1:0] REPEAT_L = CNT_W'(REPEAT_MS);
`ifdef BTN_DOUBLE_CLICK_EN
   localparam logic [CNT_W-1:0] DBL_L    = CNT_W'(DBL_MS);
`endif

   btn_state_e       state_q, state_d;
   logic             tmr_clr, tmr_hit;
   logic [CNT_W-1:0] tmr_limit;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             rep_q, rep_d;
   logic             held_q, held_d;
`ifdef BTN_DOUBLE_CLICK_EN
   logic             dbl_q, dbl_d;
`endif

   // Simultaneous press and release cancel each other out.
   logic dn_evt, up_evt;
   assign dn_evt = bus.pb_down && !bus.pb_up;
   assign up_evt = bus.pb_up && !bus.pb_down;

   btn_tick_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (tmr_clr),
      .inc_i   (bus.tick),
      .limit_i (tmr_limit),
      .hit_o   (tmr_hit)
   );

   // Threshold selected by the current state only.
   always_comb begin
      tmr_limit = LONG_L;
      case (state_q)
         LONG_HELD: tmr_limit = REPEAT_L;
`ifdef BTN_DOUBLE_CLICK_EN
         WAIT_DBL:  tmr_limit = DBL_L;
`endif
         default:   tmr_limit = LONG_L;
      endcase
   end

   // Next state and next output pulses; release beats a same-cycle threshold tick.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d = state_q;
      tmr_clr = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
      dbl_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            tmr_clr = 1'b1;  // holds the counter at 0; a tick with pb_down is not counted
            if (dn_evt) state_d = PRESSED;
         end
         PRESSED: begin
            if (up_evt) begin
               tmr_clr = 1'b1;
`ifdef BTN_DOUBLE_CLICK_EN
               state_d = WAIT_DBL;
`else
               short_d = 1'b1;
               state_d = IDLE;
`endif
            end else if (tmr_hit) begin
               long_d  = 1'b1;
               state_d = LONG_HELD;
            end
         end
         LONG_HELD: begin
            if (up_evt) begin
               tmr_clr = 1'b1;
               state_d = IDLE;
            end else if (tmr_hit) begin
               rep_d = 1'b1;
            end
         end
`ifdef BTN_DOUBLE_CLICK_EN
         WAIT_DBL: begin
            if (dn_evt) begin
               dbl_d   = 1'b1;
               tmr_clr = 1'b1;
               state_d = PRESSED;
            end else if (tmr_hit) begin
               short_d = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         held_q  <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
         dbl_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         short_q <= short_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
         held_q  <= held_d;
`ifdef BTN_DOUBLE_CLICK_EN
         dbl_q   <= dbl_d;
`endif
      end
   end

   assign bus.short_press  = short_q;
   assign bus.long_press   = long_q;
   assign bus.repeat_pulse = rep_q;
   assign bus.held         = held_q;
`ifdef BTN_DOUBLE_CLICK_EN
   assign bus.double_press = dbl_q;
`else
   assign bus.double_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier (LONG_MS=10, REPEAT_MS=4, DBL_MS=5).
// Output vectors are ordered {short_press, long_press, repeat_pulse, held, double_press}.
module tb_button_press_classifier;

   localparam int LONG_MS   = 10;
   localparam int REPEAT_MS = 4;
   localparam int DBL_MS    = 5;
`ifdef BTN_DOUBLE_CLICK_EN
   localparam bit DBL_EN = 1'b1;
`else
   localparam bit DBL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   button_press_classifier_if ifc ();

   button_press_classifier #(
      .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS), .DBL_MS(DBL_MS), .CNT_W(12)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rn, t, d, u;
      logic [4:0] exp;
      string      name;
   } vec_t;

   function automatic vec_t mk(bit rn, bit t, bit d, bit u, logic [4:0] exp, string name);
      vec_t v;
      v.rn = rn; v.t = t; v.d = d; v.u = u; v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (short,long,rep,held,dbl)", name, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, compare just after the rising edge.
   task automatic run(input bit rn, input bit t, input bit d, input bit u,
                      input logic [4:0] exp, input string name);
      logic [4:0] outs;
      logic [3:0] pulses;
      @(negedge clk);
      rst_n = rn; ifc.tick = t; ifc.pb_down = d; ifc.pb_up = u;
      @(posedge clk);
      #1;
      outs   = {ifc.short_press, ifc.long_press, ifc.repeat_pulse, ifc.held, ifc.double_press};
      pulses = {ifc.short_press, ifc.long_press, ifc.repeat_pulse, ifc.double_press};
      check(name, outs, exp);
      checks++;
      if ($countones(pulses) > 1) begin
         errors++;
         $display("FAIL %s_onehot: pulses %b, at most one may be high", name, pulses);
      end
   endtask

   // Reference model: tracks total ticks held since the press and ticks idle since release.
   bit m_pressed, m_waiting;
   int m_total, m_gap;

   task automatic model_step(input bit rn, input bit t, input bit d, input bit u,
                             output logic [4:0] exp);
      bit s, l, r, db;
      bit dn, up;
      s = 0; l = 0; r = 0; db = 0;
      dn = d && !u;
      up = u && !d;
      if (!rn) begin
         m_pressed = 0; m_waiting = 0; m_total = 0; m_gap = 0;
      end else if (m_pressed) begin
         if (up) begin
            m_pressed = 0;
            if (m_total < LONG_MS) begin
               if (DBL_EN) begin m_waiting = 1; m_gap = 0; end
               else s = 1;
            end
         end else if (t) begin
            m_total++;
            if (m_total == LONG_MS) l = 1;
            else if (m_total > LONG_MS && (m_total - LONG_MS) % REPEAT_MS == 0) r = 1;
         end
      end else if (m_waiting) begin
         if (dn) begin
            db = 1; m_waiting = 0; m_pressed = 1; m_total = 0;
         end else if (t) begin
            m_gap++;
            if (m_gap == DBL_MS) begin s = 1; m_waiting = 0; end
         end
      end else if (dn) begin
         m_pressed = 1; m_total = 0;
      end
      exp = {s, l, r, m_pressed, db};
   endtask

   vec_t tbl[$];

   initial begin
      logic [4:0] e;
      rst_n = 1'b0; ifc.tick = 1'b0; ifc.pb_down = 1'b0; ifc.pb_up = 1'b0;

      // Short press, simultaneous events in IDLE, stray release in IDLE.
      tbl.push_back(mk(0, 0, 0, 0, 5'b00000, "reset"));
      tbl.push_back(mk(1, 1, 0, 0, 5'b00000, "idle_tick"));
      tbl.push_back(mk(1, 0, 1, 1, 5'b00000, "idle_dn_up_same"));
      tbl.push_back(mk(1, 0, 1, 0, 5'b00010, "short_dn"));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 5'b00010, "short_tick"));
      tbl.push_back(mk(1, 0, 1, 0, 5'b00010, "dn_while_pressed"));
      tbl.push_back(mk(1, 0, 0, 1, {!DBL_EN, 4'b0000}, "short_up"));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 0, 5'b00000, "post_short_tick"));
      tbl.push_back(mk(1, 1, 0, 0, {DBL_EN, 4'b0000}, "post_short_tick5"));
      tbl.push_back(mk(1, 0, 0, 1, 5'b00000, "idle_up"));
      foreach (tbl[i]) run(tbl[i].rn, tbl[i].t, tbl[i].d, tbl[i].u, tbl[i].exp, tbl[i].name);

      // Long press with auto-repeat, then release.
      run(1, 0, 1, 0, 5'b00010, "long_dn");
      for (int i = 1; i <= 18; i++)
         run(1, 1, 0, 0, {1'b0, i == 10, i == 14 || i == 18, 1'b1, 1'b0}, $sformatf("long_tick%0d", i));
      run(1, 0, 0, 1, 5'b00000, "long_up");
      run(1, 1, 0, 0, 5'b00000, "long_after");

      // Release on the threshold tick; pb_down's own tick must not count.
      run(1, 1, 1, 0, 5'b00010, "thr_dn_tick");
      for (int i = 1; i <= 9; i++) run(1, 1, 0, 0, 5'b00010, "thr_tick");
      run(1, 1, 0, 1, {!DBL_EN, 4'b0000}, "thr_up_tick10");
      for (int i = 1; i <= 5; i++)
         run(1, 1, 0, 0, {DBL_EN && i == 5, 4'b0000}, "thr_after");

      // Release in LONG_HELD on a repeat-boundary tick: no pulse at all.
      run(1, 0, 1, 0, 5'b00010, "lh_dn");
      for (int i = 1; i <= 13; i++)
         run(1, 1, 0, 0, {1'b0, i == 10, 1'b0, 1'b1, 1'b0}, "lh_tick");
      run(1, 1, 0, 1, 5'b00000, "lh_up_tick14");

      // Reset mid-press discards it; the later release is ignored.
      run(1, 0, 1, 0, 5'b00010, "rst_dn");
      for (int i = 1; i <= 5; i++) run(1, 1, 0, 0, 5'b00010, "rst_tick");
      run(0, 1, 0, 0, 5'b00000, "rst_mid");
      run(1, 0, 0, 1, 5'b00000, "rst_up_ignored");
      for (int i = 1; i <= 6; i++) run(1, 1, 0, 0, 5'b00000, "rst_after");

`ifdef BTN_DOUBLE_CLICK_EN
      // Double press inside the window, and pb_down winning on the window's last tick.
      run(1, 0, 1, 0, 5'b00010, "dbl_dn1");
      run(1, 1, 0, 0, 5'b00010, "dbl_tick");
      run(1, 0, 0, 1, 5'b00000, "dbl_up1");
      run(1, 1, 0, 0, 5'b00000, "dbl_gap1");
      run(1, 1, 0, 0, 5'b00000, "dbl_gap2");
      run(1, 0, 1, 0, 5'b00011, "dbl_dn2");
      run(1, 0, 0, 1, 5'b00000, "dbl_up2");
      for (int i = 1; i <= 4; i++) run(1, 1, 0, 0, 5'b00000, "dbl_edge_gap");
      run(1, 1, 1, 0, 5'b00011, "dbl_edge_dn");
      run(1, 0, 0, 1, 5'b00000, "dbl_edge_up");
      for (int i = 1; i <= 5; i++) run(1, 1, 0, 0, {i == 5, 4'b0000}, "dbl_edge_tail");
`endif

      // Randomized traffic against the reference model.
      model_step(0, 0, 0, 0, e);
      run(0, 0, 0, 0, e, "rand_reset");
      for (int n = 0; n < 3000; n++) begin
         bit rn, t, d, u;
         rn = ($urandom_range(0, 499) != 0);
         t  = ($urandom_range(0, 2) == 0);
         d  = ($urandom_range(0, 19) == 0);
         u  = ($urandom_range(0, 39) == 0);
         model_step(rn, t, d, u, e);
         run(rn, t, d, u, e, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter LONG_MS, default 1000, hold duration in ticks before a long press is declared.
REQ-002 Parameter REPEAT_MS, default 200, tick period of auto-repeat pulses after a long press.
REQ-003 Parameter DBL_MS, default 300, double-press window in ticks; used only with BTN_DOUBLE_CLICK_EN.
REQ-004 Parameter CNT_W, default 12, tick counter width.
REQ-005 clk  in  1  the clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  in  1  reset; the block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-007 tick  in  1  1 ms enable strobe, one clk wide.
REQ-008 pb_down  in  1  debounced press event, one clk wide.
REQ-009 pb_up  in  1  debounced release event, one clk wide.
REQ-010 short_press  out  1  one-clk pulse, short press classified.
REQ-011 long_press  out  1  one-clk pulse, hold reached LONG_MS.
REQ-012 repeat_pulse  out  1  one-clk pulse every REPEAT_MS ticks while held after long_press.
REQ-013 held  out  1  level, high from the cycle after pb_down until the cycle after pb_up.
REQ-014 double_press  out  1  one-clk pulse, second press inside window; tied 0 without BTN_DOUBLE_CLICK_EN.

Function
REQ-015 All outputs SHALL be registered, with one-clk latency from the qualifying input cycle.
REQ-016 States SHALL be IDLE, PRESSED, LONG_HELD, WAIT_DBL (WAIT_DBL exists only with the macro).
REQ-017 IDLE: pb_down -> PRESSED, counter cleared to 0; tick in the same cycle SHALL NOT count.
REQ-018 PRESSED: each tick increments the counter; the tick that brings it to LONG_MS -> long_press, counter cleared, LONG_HELD.
REQ-019 PRESSED: pb_up -> short_press, IDLE; pb_up SHALL take priority over a threshold tick in the same cycle.
REQ-020 LONG_HELD: each tick increments the counter; reaching REPEAT_MS -> repeat_pulse, counter cleared.
REQ-021 LONG_HELD: pb_up -> IDLE, with no short_press and no repeat_pulse in that cycle.
REQ-022 pb_up in IDLE, pb_down in PRESSED or LONG_HELD, and pb_down together with pb_up SHALL be ignored, with no state change.
REQ-023 tick without a press event SHALL NOT change state in IDLE.
REQ-024 The counter SHALL never wrap: compare-and-clear occurs before overflow; elaboration SHALL fail if LONG_MS, REPEAT_MS or DBL_MS >= 2**CNT_W.
REQ-025 At most one of short_press, long_press, repeat_pulse, double_press SHALL be high in any cycle.

Reset
REQ-026 rst_n low at a rising edge -> state IDLE, counter 0, all outputs 0 on the next cycle.
REQ-027 Reset mid-press SHALL discard the press; a later pb_up SHALL be ignored per REQ-022.

Configuration
REQ-028 Macro BTN_DOUBLE_CLICK_EN SHALL gate the double-press feature.
REQ-029 Defined: PRESSED pb_up -> WAIT_DBL, counter cleared, short_press deferred.
REQ-030 Defined, WAIT_DBL: pb_down before DBL_MS ticks -> double_press, PRESSED (counter 0).
REQ-031 Defined, WAIT_DBL: counter reaching DBL_MS -> short_press, IDLE; pb_down in that same cycle SHALL win.
REQ-032 Undefined: WAIT_DBL absent, double_press constant 0, short_press per REQ-019.

Structure
REQ-033 State enum and default timing constants SHALL reside in package watch_btn_pkg.
REQ-034 The tick counter with compare/clear SHALL be sub-module btn_tick_timer; the FSM stays in the top module.

Verification (LONG_MS=10, REPEAT_MS=4, DBL_MS=5)
REQ-035 pb_down, 3 ticks, pb_up -> one short_press one clk after pb_up; held high 1 clk after pb_down to 1 clk after pb_up.
REQ-036 pb_down, 18 ticks, pb_up -> long_press after tick 10, repeat_pulse after ticks 14 and 18, no short_press.
REQ-037 pb_up in the same cycle as tick 10 -> short_press only, no long_press.
REQ-038 rst_n low for 1 clk after 5 held ticks, then pb_up -> all outputs 0, no pulses.
REQ-039 Macro on: short press, 2 ticks, pb_down -> double_press; separately, short press then 5 ticks idle -> short_press after tick 5.
REQ-040 pb_down and pb_up in the same cycle in IDLE -> no state change, all outputs 0.
